periph_rx_fifo: RTL and testbench

- Parametrised peripheral receiver; successor to the single-entry send/ack peripheral FSM.
- Accepts words from the CPU side over a 4-phase send/ack handshake and buffers them in a DEPTH-entry FIFO.
- Exposes a first-word-fall-through read port to downstream peripheral logic.
- Applies backpressure by withholding ack while the FIFO is full.

---
 rtl/periph_rx_fifo.sv | 142 ++++++++++++++
 tb/tb_periph_rx_fifo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/periph_rx_fifo.sv
// ============================================================================
// Module      : periph_rx_fifo
// Description : CPU-side 4-phase send/ack receiver feeding a DEPTH-entry
//               first-word-fall-through FIFO; ack is withheld while full.
//               Optional macro STALL_CNT_EN adds a saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module periph_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk1,
    input  logic              rst1,
    input  logic              send,
    input  logic [DATA_W-1:0] dataInput,
    output logic              ack,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
`ifdef STALL_CNT_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ACK  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic w_wr;
    logic w_pop;

    // A write only happens on the IDLE->ACK transition, so one per handshake.
    assign w_wr  = (state_q == S_IDLE) && send && !full;
    assign w_pop = rd_en && !empty;

    // ------------------------------------------------------------------
    // Handshake FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk1 or posedge rst1) begin
        if (rst1) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_wr)  state_d = S_ACK;
            S_ACK:   if (!send) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ack = 1'b0;
        if (state_q == S_ACK) begin
            ack = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (w_wr) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        case ({w_wr, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk1 or posedge rst1) begin
        if (rst1) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset: stale words are unreachable once pointers clear.
    always_ff @(posedge clk1) begin
        if (w_wr) begin
            mem_q[wptr_q] <= dataInput;
        end
    end

    assign rd_data = mem_q[rptr_q];
    assign count   = count_q;
    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));

`ifdef STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == S_IDLE) && send && full && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk1 or posedge rst1) begin
        if (rst1) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_periph_rx_fifo.sv
// ============================================================================
// Module      : tb_periph_rx_fifo
// Description : Scoreboard bench for periph_rx_fifo: directed scenarios plus
//               randomized CPU/consumer traffic against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_periph_rx_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk1 = 1'b0;
    logic              rst1;
    logic              send;
    logic [DATA_W-1:0] dataInput;
    logic              ack;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              empty;
    logic              full;
    logic [CNT_W-1:0]  count;
`ifdef STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    periph_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk1      (clk1),
        .rst1      (rst1),
        .send      (send),
        .dataInput (dataInput),
        .ack       (ack),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
`ifdef STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .count     (count)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        bit ack;
        int cnt;
        int stall;
    } exp_t;

    // Reference model: contents as a plain queue, plus whether the CPU's
    // current request has already been accepted.
    logic [DATA_W-1:0] m_q[$];
    bit                m_ack;
    int                m_stall;

    exp_t              st_q[$];
    logic [DATA_W-1:0] sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Drive one cycle of stimulus; the model predicts the effect of the
    // next rising edge, and status for the current cycle is queued first.
    task automatic step(input logic s, input logic [DATA_W-1:0] d, input logic r);
        exp_t e;
        bit   do_wr, stalled, do_pop;
        e.ack = m_ack; e.cnt = m_q.size(); e.stall = m_stall;
        st_q.push_back(e);
        send = s; dataInput = d; rd_en = r;
        do_wr   = !m_ack && s && (m_q.size() < DEPTH);
        stalled = !m_ack && s && (m_q.size() == DEPTH);
        do_pop  = r && (m_q.size() > 0);
        if (do_pop) begin
            sb_q.push_back(m_q[0]);
            void'(m_q.pop_front());
        end
        if (do_wr) m_q.push_back(d);
        if (stalled && m_stall < 65535) m_stall++;
        m_ack = m_ack ? bit'(s) : do_wr;
        @(posedge clk1); #2;
    endtask

    task automatic hs(input logic [DATA_W-1:0] d);
        step(1'b1, d, 1'b0);
        step(1'b0, d, 1'b0);
    endtask

    task automatic model_reset();
        m_q.delete(); sb_q.delete(); st_q.delete();
        m_ack = 0; m_stall = 0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ack"},   ack,   0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"},  full,  0);
`ifdef STALL_CNT_EN
        chk({tag, "_stall"}, stall_cnt, 0);
`endif
    endtask

    // Monitor: mid-cycle status check and pop-data scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk1);
            if (!rst1 && st_q.size() > 0) begin
                e = st_q.pop_front();
                chk("ack",   ack,   e.ack);
                chk("count", count, e.cnt);
                chk("empty", empty, e.cnt == 0);
                chk("full",  full,  e.cnt == DEPTH);
`ifdef STALL_CNT_EN
                chk("stall_cnt", stall_cnt, e.stall);
`endif
                if (rd_en && !empty) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL pop_data: DUT popped %0h, model expected no pop", rd_data);
                    end else begin
                        chk("pop_data", rd_data, sb_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        bit                ns, nr;
        logic [DATA_W-1:0] nd;

        rst1 = 1'b1; send = 1'b0; dataInput = '0; rd_en = 1'b0;
        model_reset();
        repeat (2) @(posedge clk1);
        #2;
        chk_reset_state("por");
        rst1 = 1'b0;

        // Single transfer
        step(1'b1, 8'hA5, 1'b0);
        step(1'b0, 8'hA5, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Fill, backpressure, pop at full with pending write
        for (int i = 1; i <= 4; i++) hs(8'(i));
        repeat (3) step(1'b1, 8'h05, 1'b0);
        step(1'b1, 8'h05, 1'b1);
        step(1'b1, 8'h05, 1'b0);
        step(1'b0, 8'h05, 1'b0);
        repeat (4) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Wrap-around write/read pairs
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(8'h10 + i), 1'b0);
            step(1'b0, 8'(8'h10 + i), 1'b1);
        end

        // Simultaneous push/pop at count=2
        hs(8'h21); hs(8'h22);
        step(1'b1, 8'h23, 1'b1);
        step(1'b0, 8'h23, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b1);

        // Empty pop, then send held with changing data
        step(1'b0, 8'h00, 1'b1);
        repeat (5) step(1'b1, 8'($urandom), 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Asynchronous reset mid-handshake at count=3, ack=1
        hs(8'h31); hs(8'h32);
        step(1'b1, 8'h33, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        rst1 = 1'b1;
        #1;
        chk_reset_state("async_rst");
        model_reset();
        @(posedge clk1); #2;
        rst1 = 1'b0;
        step(1'b1, 8'h77, 1'b0);
        step(1'b1, 8'h77, 1'b0);
        step(1'b0, 8'h77, 1'b0);
        step(1'b0, 8'h00, 1'b1);

        // Randomized traffic: light reads first (to hit full), then heavy
        for (int i = 0; i < 600; i++) begin
            ns = send; nd = dataInput;
            if (!send) begin
                if ($urandom_range(0, 2) == 0) begin ns = 1'b1; nd = 8'($urandom); end
            end else if (m_ack) begin
                if ($urandom_range(0, 1) == 0) ns = 1'b0;
                else if ($urandom_range(0, 3) == 0) nd = 8'($urandom);
            end else if ($urandom_range(0, 9) == 0) begin
                ns = 1'b0;
            end
            nr = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(ns, nd, nr);
        end
        step(1'b0, 8'h00, 1'b0);
        repeat (DEPTH + 1) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        chk("sb_leftover", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
